multi_core_mem_arbiter: RTL and testbench



---
 rtl/multi_core_mem_arbiter_if.sv | 39 +++
 rtl/multi_core_mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_multi_core_mem_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/multi_core_mem_arbiter_if.sv
// Bus bundle between N cores, the arbiter and the shared memory port.
//   m_*  : per-core native valid/ready memory ports (flattened, master i at slice i)
//   s_*  : single shared memory port driven by the arbiter
// Modports:
//   slave  - arbiter view: serves the cores, drives the shared port
//   master - environment view: cores and shared memory
interface multi_core_mem_arbiter_if #(
    parameter int N_MASTERS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    localparam int SW = DATA_W / 8;

    logic [N_MASTERS-1:0]        m_valid;
    logic [N_MASTERS-1:0]        m_instr;
    logic [N_MASTERS*ADDR_W-1:0] m_addr;
    logic [N_MASTERS*DATA_W-1:0] m_wdata;
    logic [N_MASTERS*SW-1:0]     m_wstrb;
    logic [N_MASTERS-1:0]        m_ready;
    logic [DATA_W-1:0]           m_rdata;

    logic                        s_valid;
    logic                        s_instr;
    logic [ADDR_W-1:0]           s_addr;
    logic [DATA_W-1:0]           s_wdata;
    logic [SW-1:0]               s_wstrb;
    logic                        s_ready;
    logic [DATA_W-1:0]           s_rdata;

    modport slave (
        input  m_valid, m_instr, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, s_valid, s_instr, s_addr, s_wdata, s_wstrb
    );

    modport master (
        output m_valid, m_instr, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        input  m_ready, m_rdata, s_valid, s_instr, s_addr, s_wdata, s_wstrb
    );
endinterface

// File: rtl/multi_core_mem_arbiter.sv
// N-master round-robin arbiter onto one shared memory port, with per-master
// enable masking and a slave-timeout watchdog. All outputs are registered.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   master_en   - per-master enable, disabled masters' requests are ignored
//   bus         - core ports (m_*) and shared memory port (s_*)
//   grant       - one-hot owner while a transaction is in flight, 0 when idle
//   busy        - high while a transaction is in flight or responding
//   err_valid   - one-cycle pulse when a transaction completed by timeout
//   err_master  - index of the master that last timed out
//
// state | meaning
// IDLE  | waiting for an enabled request, round-robin pick from ptr
// BUSY  | shared port request outstanding, watchdog counting
// RESP  | completion pulse to the owner, pointer advances past it
module multi_core_mem_arbiter #(
    parameter int          N_MASTERS = 3,
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] master_en,
    multi_core_mem_arbiter_if.slave bus,
    output logic [N_MASTERS-1:0] grant,
    output logic                 busy,
    output logic                 err_valid,
    output logic [((N_MASTERS > 1) ? $clog2(N_MASTERS) : 1)-1:0] err_master
);
    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SW = DATA_W / 8;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t state_q, state_d;

    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        own_q, own_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [N_MASTERS-1:0] grant_d;
    logic                 busy_d;
    logic                 err_valid_d;
    logic [IW-1:0]        err_master_d;
    logic [N_MASTERS-1:0] m_ready_q, m_ready_d;
    logic [DATA_W-1:0]    m_rdata_q, m_rdata_d;
    logic                 s_valid_q, s_valid_d;
    logic                 s_instr_q, s_instr_d;
    logic [ADDR_W-1:0]    s_addr_q, s_addr_d;
    logic [DATA_W-1:0]    s_wdata_q, s_wdata_d;
    logic [SW-1:0]        s_wstrb_q, s_wstrb_d;

    logic [N_MASTERS-1:0] req;
    logic                 req_any;
    logic [IW-1:0]        pick;
    logic                 timeout_hit;

    // First requesting index at or after p, wrapping. The sum p+k never
    // exceeds 2*N-2, so one extra bit is enough before the wrap subtract.
    function automatic logic [IW-1:0] rr_pick(input logic [N_MASTERS-1:0] r,
                                              input logic [IW-1:0] p);
        logic [IW-1:0] sel;
        logic          hit;
        logic [IW:0]   idx;
        sel = '0;
        hit = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            idx = {1'b0, p} + (IW+1)'(k);
            if (idx >= (IW+1)'(N_MASTERS)) begin
                idx = idx - (IW+1)'(N_MASTERS);
            end
            if (!hit && r[idx[IW-1:0]]) begin
                hit = 1'b1;
                sel = idx[IW-1:0];
            end
        end
        return sel;
    endfunction

    assign req         = bus.m_valid & master_en;
    assign req_any     = |req;
    assign pick        = rr_pick(req, ptr_q);
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_any) state_d = S_BUSY;
            S_BUSY:  if (bus.s_ready || timeout_hit) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d        = ptr_q;
        own_d        = own_q;
        cnt_d        = cnt_q;
        grant_d      = grant;
        busy_d       = busy;
        err_valid_d  = 1'b0;
        err_master_d = err_master;
        m_ready_d    = '0;
        m_rdata_d    = m_rdata_q;
        s_valid_d    = s_valid_q;
        s_instr_d    = s_instr_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_wstrb_d    = s_wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    own_d     = pick;
                    grant_d   = {{(N_MASTERS-1){1'b0}}, 1'b1} << pick;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    s_valid_d = 1'b1;
                    s_instr_d = bus.m_instr[pick];
                    s_addr_d  = bus.m_addr[pick*ADDR_W +: ADDR_W];
                    s_wdata_d = bus.m_wdata[pick*DATA_W +: DATA_W];
                    s_wstrb_d = bus.m_wstrb[pick*SW +: SW];
                end
            end
            S_BUSY: begin
                if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
                // A slave answer in the timeout cycle counts as a normal completion.
                if (bus.s_ready) begin
                    m_rdata_d = bus.s_rdata;
                    m_ready_d = grant;
                    s_valid_d = 1'b0;
                end else if (timeout_hit) begin
                    m_rdata_d    = DATA_W'(ERR_RDATA);
                    m_ready_d    = grant;
                    err_valid_d  = 1'b1;
                    err_master_d = own_q;
                    s_valid_d    = 1'b0;
                end
            end
            S_RESP: begin
                grant_d = '0;
                busy_d  = 1'b0;
                ptr_d   = (own_q == IW'(N_MASTERS - 1)) ? '0 : own_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            own_q      <= '0;
            cnt_q      <= '0;
            grant      <= '0;
            busy       <= 1'b0;
            err_valid  <= 1'b0;
            err_master <= '0;
            m_ready_q  <= '0;
            m_rdata_q  <= '0;
            s_valid_q  <= 1'b0;
            s_instr_q  <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wstrb_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            own_q      <= own_d;
            cnt_q      <= cnt_d;
            grant      <= grant_d;
            busy       <= busy_d;
            err_valid  <= err_valid_d;
            err_master <= err_master_d;
            m_ready_q  <= m_ready_d;
            m_rdata_q  <= m_rdata_d;
            s_valid_q  <= s_valid_d;
            s_instr_q  <= s_instr_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_wstrb_q  <= s_wstrb_d;
        end
    end

    assign bus.m_ready = m_ready_q;
    assign bus.m_rdata = m_rdata_q;
    assign bus.s_valid = s_valid_q;
    assign bus.s_instr = s_instr_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_wdata = s_wdata_q;
    assign bus.s_wstrb = s_wstrb_q;
endmodule

// File: tb/tb_multi_core_mem_arbiter.sv
module tb_multi_core_mem_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] master_en;
    logic [2:0] grant;
    logic       busy;
    logic       err_valid;
    logic [1:0] err_master;

    multi_core_mem_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    multi_core_mem_arbiter #(
        .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
        .TIMEOUT(TO), .ERR_RDATA(32'hDEADBEEF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .master_en  (master_en),
        .bus        (bus),
        .grant      (grant),
        .busy       (busy),
        .err_valid  (err_valid),
        .err_master (err_master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        bit          err;
        int          len;
        logic [31:0] addr;
        logic [3:0]  wstrb;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          ptr_m  = 0;
    int          slave_lat = 0;
    bit          slave_never = 1'b0;
    logic [31:0] key;
    logic [31:0] addr_of[3];
    logic [3:0]  strb_of[3];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_master(input int i, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] st, input bit ins);
        bus.m_addr[i*32 +: 32] = a;
        bus.m_wdata[i*32 +: 32] = wd;
        bus.m_wstrb[i*4 +: 4]  = st;
        bus.m_instr[i]         = ins;
        addr_of[i] = a;
        strb_of[i] = st;
    endtask

    // Reference round-robin: push the next n completions for a constant request mask.
    task automatic push_model(input logic [2:0] r, input int n, input bit to_err);
        exp_t e;
        for (int t = 0; t < n; t++) begin
            e.idx = -1;
            for (int k = 0; k < N; k++) begin
                if (e.idx < 0 && r[(ptr_m + k) % N]) e.idx = (ptr_m + k) % N;
            end
            e.addr  = addr_of[e.idx];
            e.wstrb = strb_of[e.idx];
            e.err   = to_err;
            e.rdata = to_err ? 32'hDEADBEEF : (addr_of[e.idx] ^ key);
            e.len   = to_err ? TO : slave_lat + 1;
            sb.push_back(e);
            ptr_m = (e.idx + 1) % N;
        end
    endtask

    // Acts as the shared memory and checks completions against the scoreboard.
    task automatic run_phase(input int max_cyc);
        int   cyc = 0;
        int   svc = 0;
        int   len_seen = 0;
        exp_t e;
        while (sb.size() > 0 && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (bus.s_valid) begin
                svc++;
                if (svc == 1) begin
                    chk("s_addr", bus.s_addr, sb[0].addr);
                    chk("s_wstrb", bus.s_wstrb, sb[0].wstrb);
                    chk("grant_busy", grant, 64'(1) << sb[0].idx);
                end
            end else if (svc > 0) begin
                len_seen = svc;
                svc = 0;
            end
            if (|bus.m_ready) begin
                e = sb.pop_front();
                chk("m_ready", bus.m_ready, 64'(1) << e.idx);
                chk("grant_resp", grant, 64'(1) << e.idx);
                chk("m_rdata", bus.m_rdata, e.rdata);
                chk("err_valid", err_valid, e.err);
                if (e.err) chk("err_master", err_master, e.idx);
                chk("s_valid_len", len_seen, e.len);
                if (sb.size() == 0) bus.m_valid = '0;
            end else if (err_valid) begin
                chk("err_without_ready", err_valid, 0);
            end
            bus.s_ready = bus.s_valid && !slave_never && (svc > slave_lat);
            bus.s_rdata = bus.s_addr ^ key;
        end
        if (sb.size() > 0) begin
            chk("phase_timeout", sb.size(), 0);
            sb.delete();
            bus.m_valid = '0;
        end
        bus.s_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_ready", bus.m_ready, 0);
        end
        chk("idle_grant", grant, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_s_valid"}, bus.s_valid, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_m_ready"}, bus.m_ready, 0);
        chk({tag, "_m_rdata"}, bus.m_rdata, 0);
        chk({tag, "_err_valid"}, err_valid, 0);
        chk({tag, "_err_master"}, err_master, 0);
        chk({tag, "_s_addr"}, bus.s_addr, 0);
        chk({tag, "_s_wstrb"}, bus.s_wstrb, 0);
    endtask

    initial begin
        int w;
        master_en   = 3'b111;
        bus.m_valid = '0;
        bus.s_ready = 1'b0;
        bus.s_rdata = '0;
        key         = 32'h12345678 ^ 32'h100;
        set_master(0, 32'h1000, 32'h0,        4'h0,    1'b1);
        set_master(1, 32'h100,  32'h0,        4'h0,    1'b0);
        set_master(2, 32'h2000, 32'h00000055, 4'b0011, 1'b0);
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // Round-robin with all masters requesting, immediate slave.
        slave_lat = 0;
        bus.m_valid = 3'b111;
        push_model(3'b111, 6, 1'b0);
        run_phase(100);

        // Single read by master 1, slave answers on its third cycle.
        slave_lat = 2;
        bus.m_valid = 3'b010;
        push_model(3'b010, 1, 1'b0);
        run_phase(40);

        // Master 1 disabled, everyone requests.
        slave_lat = 1;
        master_en = 3'b101;
        bus.m_valid = 3'b111;
        push_model(3'b101, 4, 1'b0);
        run_phase(100);
        master_en = 3'b111;

        // Master 2 write, slave never answers.
        set_master(2, 32'h2000, 32'hCAFEF00D, 4'hF, 1'b0);
        slave_never = 1'b1;
        bus.m_valid = 3'b100;
        push_model(3'b100, 1, 1'b1);
        run_phase(60);

        // Pointer must have moved past master 2.
        slave_never = 1'b0;
        slave_lat = 0;
        bus.m_valid = 3'b111;
        push_model(3'b111, 1, 1'b0);
        run_phase(40);

        // Slave answers in exactly the timeout cycle.
        slave_lat = TO - 1;
        bus.m_valid = 3'b010;
        push_model(3'b010, 1, 1'b0);
        run_phase(60);
        chk("err_master_hold", err_master, 2);

        // Reset while a request is outstanding.
        slave_never = 1'b1;
        bus.m_valid = 3'b100;
        w = 0;
        while (!bus.s_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("pre_reset_busy", bus.s_valid, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.m_valid = 3'b111;
        @(negedge clk);
        chk_reset_state("midreset");
        rst = 1'b0;
        slave_never = 1'b0;
        slave_lat = 0;
        ptr_m = 0;
        push_model(3'b111, 1, 1'b0);
        run_phase(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
